// File: rtl/lsu_mmio.sv
// lsu_mmio: RV32I load/store unit with programmable RAM read wait states and memory-mapped I/O.
// One access in flight at a time; accepted in IDLE, completed by a single-cycle o_done pulse.
module lsu_mmio #(
  parameter int DMEM_WORDS  = 2048,
  parameter int WAIT_CYCLES = 1,
  parameter int NUM_HEX     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  output logic                 o_ready,
  input  logic                 i_we,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  output logic                 o_done,
  output logic [31:0]          o_rdata,
  output logic                 o_err,
  input  logic [31:0]          i_io_sw,
  input  logic [3:0]           i_io_btn,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd
);
  // state | meaning
  // IDLE  | o_ready=1, waiting for i_req
  // WAIT  | RAM read in flight, wait_cnt counting down to 0
  // RESP  | o_done pulse, o_rdata/o_err valid
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int          IDX_W     = $clog2(DMEM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DMEM_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        accept, off_ok, is_ram, is_io_rw, is_io_ro, misaligned, req_err, wr_en;
  logic [3:0]  be;
  logic [31:0] wlane, io_rd;
  logic [31:0] ledr_q, ledg_q, hex_q, lcd_q;
  logic [31:0] sw_s1, sw_s2;
  logic [3:0]  btn_s1, btn_s2;
  logic [31:0] io_word_q, ram_word, ld_src, ld_shift, ld_ext;
  logic        err_q, we_q, ram_q, uns_q;
  logic [1:0]  size_q, lane_q;
  logic [IDX_W-1:0] idx_q, rd_idx;
  logic [31:0] mem [DMEM_WORDS];

  assign accept     = i_req && (state == IDLE);
  assign off_ok     = (i_addr[11:2] == '0);
  assign is_ram     = (i_addr < RAM_BYTES);
  // pages 0x10000..0x10003 are the RW registers, 0x10010..0x10011 the RO inputs
  assign is_io_rw   = (i_addr[31:14] == 18'h04000) && off_ok;
  assign is_io_ro   = (i_addr[31:13] == 19'h08008) && off_ok;
  assign misaligned = ((i_size == 2'b01) && i_addr[0]) ||
                      ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));
  assign req_err    = misaligned || (i_size == 2'b11) ||
                      !(is_ram || is_io_rw || is_io_ro) || (i_we && is_io_ro);
  assign wr_en      = accept && i_we && !req_err;

  always_comb begin
    be    = 4'b1111;
    wlane = i_wdata;
    case (i_size)
      2'b00: begin
        be    = 4'b0001 << i_addr[1:0];
        wlane = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << i_addr[1:0];
        wlane = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    io_rd = '0;
    if (is_io_ro) begin
      io_rd = i_addr[12] ? {28'd0, btn_s2} : sw_s2;
    end else begin
      case (i_addr[13:12])
        2'd0:    io_rd = ledr_q;
        2'd1:    io_rd = ledg_q;
        2'd2:    io_rd = hex_q;
        default: io_rd = lcd_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)
              state_nxt = (is_ram && !i_we && !req_err && (WAIT_CYCLES > 0)) ? WAIT : RESP;
      WAIT: if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      ram_q     <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      idx_q     <= '0;
      io_word_q <= '0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      hex_q     <= '0;
      lcd_q     <= '0;
      sw_s1     <= '0;
      sw_s2     <= '0;
      btn_s1    <= '0;
      btn_s2    <= '0;
    end else begin
      sw_s1  <= i_io_sw;
      sw_s2  <= sw_s1;
      btn_s1 <= i_io_btn;
      btn_s2 <= btn_s1;
      if (accept) begin
        err_q     <= req_err;
        we_q      <= i_we;
        ram_q     <= is_ram;
        uns_q     <= i_unsigned;
        size_q    <= i_size;
        lane_q    <= i_addr[1:0];
        idx_q     <= i_addr[IDX_W+1:2];
        io_word_q <= io_rd;
        wait_cnt  <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (wr_en && is_io_rw) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            case (i_addr[13:12])
              2'd0:    ledr_q[8*b +: 8] <= wlane[8*b +: 8];
              2'd1:    ledg_q[8*b +: 8] <= wlane[8*b +: 8];
              2'd2:    hex_q[8*b +: 8]  <= wlane[8*b +: 8];
              default: lcd_q[8*b +: 8]  <= wlane[8*b +: 8];
            endcase
          end
        end
      end
    end
  end

  // read address follows the live request in IDLE so a zero-wait load has data in RESP
  assign rd_idx = (state == IDLE) ? i_addr[IDX_W+1:2] : idx_q;

  always_ff @(posedge i_clk) begin
    if (wr_en && is_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[i_addr[IDX_W+1:2]][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
    ram_word <= mem[rd_idx];
  end

  assign ld_src   = ram_q ? ram_word : io_word_q;
  assign ld_shift = ld_src >> {lane_q, 3'b000};

  always_comb begin
    ld_ext = ld_shift;
    case (size_q)
      2'b00:   ld_ext = {{24{!uns_q && ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_ext = {{16{!uns_q && ld_shift[15]}}, ld_shift[15:0]};
      default: ;
    endcase
  end

  assign o_ready   = (state == IDLE);
  assign o_done    = (state == RESP);
  assign o_err     = o_done && err_q;
  assign o_rdata   = (o_done && !we_q && !err_q) ? ld_ext : 32'd0;
  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

  // only the four bytes of the HEX register exist; higher digits stay blank
  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
    if (k < 4) begin : g_drv
      assign o_io_hex[7*k +: 7] = hex_q[8*k +: 7];
    end else begin : g_off
      assign o_io_hex[7*k +: 7] = 7'd0;
    end
  end

endmodule
